// File: rtl/slot_index_arbiter.sv
// -----------------------------------------------------------------------------
// slot_index_arbiter
//   Two requesters share one sign-extend + add + modulo datapath. A request is
//   an 8-bit unsigned base pointer plus a 4-bit signed offset. The sum is
//   reduced into [0, MOD-1] by adding or subtracting MOD, one step per cycle.
//   The arbiter is round-robin, and both sides use valid/ready handshakes.
//
// Ports
//   clk, reset              single rising-edge clock, synchronous active-high reset
//   req0_valid/ready/ptr/off requester 0 handshake and payload
//   req1_valid/ready/ptr/off requester 1 handshake and payload
//   rsp_valid/ready         result handshake
//   rsp_id                  requester the result belongs to
//   rsp_slot                (ptr + sext(off)) mod MOD
//   busy                    high whenever a job is in flight
// -----------------------------------------------------------------------------
module slot_index_arbiter #(
  parameter int MOD    = 8,
  parameter int SLOT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [7:0]        req0_ptr,
  input  logic [3:0]        req0_off,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [7:0]        req1_ptr,
  input  logic [3:0]        req1_off,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [SLOT_W-1:0] rsp_slot,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  localparam logic signed [12:0] MOD_S = 13'(MOD);

  state_t             state, next_state;
  logic signed [12:0] acc;
  logic               job_id;
  logic               last_grant;
  logic               grant0, grant1;
  logic               accept;
  logic               in_range;
  logic [7:0]         sel_ptr;
  logic [3:0]         sel_off;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0   = req0_valid & (~req1_valid | last_grant);
    grant1   = req1_valid & (~req0_valid | ~last_grant);
    accept   = (state == IDLE) & (grant0 | grant1);
    sel_ptr  = grant1 ? req1_ptr : req0_ptr;
    sel_off  = grant1 ? req1_off : req0_off;
    in_range = (acc >= 13'sd0) && (acc < MOD_S);
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of process ordering.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would infer a latch.
    next_state = state;
    case (state)
      IDLE:    if (accept)                next_state = REDUCE;
      REDUCE:  if (in_range)              next_state = DONE;
      DONE:    if (rsp_ready)             next_state = IDLE;
      default:                            next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    rsp_valid  = (state == DONE);
    busy       = (state != IDLE);
  end

  // Datapath: job capture, iterative modulo correction, result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      job_id     <= 1'b0;
      last_grant <= 1'b1;
      rsp_slot   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            job_id     <= grant1;
            last_grant <= grant1;
            // Zero-extended pointer plus sign-extended offset; the 13-bit
            // two's-complement result covers -8..262.
            acc        <= {5'b0, sel_ptr} + {{9{sel_off[3]}}, sel_off};
          end
        end
        REDUCE: begin
          if (acc < 13'sd0)       acc <= acc + MOD_S;
          else if (acc >= MOD_S)  acc <= acc - MOD_S;
          else begin
            rsp_slot <= acc[SLOT_W-1:0];
            rsp_id   <= job_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_index_arbiter.sv
// -----------------------------------------------------------------------------
// tb_slot_index_arbiter
//   Scoreboard bench for slot_index_arbiter (MOD=8). Stimulus pushes the
//   hand-computed expected response when a request is accepted. A separate
//   monitor checks every response cycle against the head of the queue.
// -----------------------------------------------------------------------------
module tb_slot_index_arbiter;

  localparam int MOD    = 8;
  localparam int SLOT_W = 3;

  typedef struct {
    bit       id;
    bit [2:0] slot;
    int       lat;
    int       acc_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [7:0]        req0_ptr, req1_ptr;
  logic [3:0]        req0_off, req1_off;
  logic              rsp_valid, rsp_ready;
  logic              rsp_id;
  logic [SLOT_W-1:0] rsp_slot;
  logic              busy;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rise_cyc = 0;
  bit   prev_valid = 1'b0;

  slot_index_arbiter #(.MOD(MOD), .SLOT_W(SLOT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_ptr   (req0_ptr),
    .req0_off   (req0_off),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_ptr   (req1_ptr),
    .req1_off   (req1_off),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_slot   (rsp_slot),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle the DUT presents a response.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) rise_cyc = cyc;
      if (rsp_valid) begin
        check("no_req_ready_in_done", int'(req0_ready | req1_ready), 0);
        if (q.size() == 0) begin
          check("rsp_expected", q.size(), 1);
        end else begin
          check("rsp_id", int'(rsp_id), int'(q[0].id));
          check("rsp_slot", int'(rsp_slot), int'(q[0].slot));
          if (rsp_ready) begin
            check("latency", rise_cyc - q[0].acc_cyc, q[0].lat);
            void'(q.pop_front());
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  function automatic void push_exp(input bit id, input bit [2:0] slot, input int k);
    exp_t e;
    e.id = id; e.slot = slot; e.lat = k + 2; e.acc_cyc = cyc;
    q.push_back(e);
  endfunction

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(q.size() == 0 && !busy), 1);
  endtask

  // Single request on one requester; waits for accept, then for the result.
  task automatic send(input bit id, input bit [7:0] ptr, input bit [3:0] off,
                      input bit [2:0] slot, input int k);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_ptr = ptr; req1_off = off; end
    else    begin req0_valid = 1'b1; req0_ptr = ptr; req0_off = off; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        push_exp(id, slot, k);
      end
    end
    check("accept", int'(got), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    bit got;
    bit w;
    reset      = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ptr   = '0;   req1_ptr   = '0;
    req0_off   = '0;   req1_off   = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_busy",      int'(busy), 0);
    check("reset_rsp_slot",  int'(rsp_slot), 0);
    check("reset_rsp_id",    int'(rsp_id), 0);
    check("reset_no_ready",  int'(req0_ready | req1_ready), 0);

    // Directed single requests: id, ptr, off, expected slot, corrections k.
    send(1'b0, 8'd5,   4'h0, 3'd5, 0);
    send(1'b0, 8'd10,  4'h4, 3'd6, 1);
    send(1'b1, 8'd0,   4'hF, 3'd7, 1);
    send(1'b0, 8'd0,   4'h8, 3'd0, 1);
    send(1'b1, 8'd8,   4'h0, 3'd0, 1);
    send(1'b1, 8'd7,   4'h0, 3'd7, 0);
    send(1'b0, 8'd255, 4'h7, 3'd6, 32);

    // Both valid continuously: grants alternate, first job back-pressured.
    // The last accept above was req0, so req1 wins the first tie here.
    // Re-align to req0 first by granting one req1 job alone.
    send(1'b1, 8'd3, 4'h1, 3'd4, 0);
    @(posedge clk); #1;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_ptr = 8'd1;  req0_off = 4'h1;   // 2, k=0
    req1_valid = 1'b1; req1_ptr = 8'd20; req1_off = 4'hD;   // 17 -> 1, k=2
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = 1'b1;
      end
      check("tie_accept", int'(got), 1);
      check("one_ready", int'(req0_ready & req1_ready), 0);
      w = req1_ready;
      check("grant_order", int'(w), i % 2);
      if (w) push_exp(1'b1, 3'd1, 2);
      else   push_exp(1'b0, 3'd2, 0);
      if (i == 0) begin
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
          @(negedge clk);
          if (rsp_valid) got = 1'b1;
        end
        check("stall_rsp_valid", int'(got), 1);
        repeat (5) @(negedge clk);
        check("stall_still_valid", int'(rsp_valid), 1);
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();

    // Reset while in REDUCE on a req1 job: job is discarded, req0 wins next tie.
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_ptr = 8'd255; req1_off = 4'h7;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (req1_ready) got = 1'b1;
    end
    check("abort_accept", int'(got), 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b1; req0_ptr = 8'd3;  req0_off = 4'h2;   // 5, k=0
    req1_valid = 1'b1; req1_ptr = 8'd9;  req1_off = 4'h0;
    @(negedge clk);
    check("abort_busy",      int'(busy), 0);
    check("abort_rsp_valid", int'(rsp_valid), 0);
    check("post_reset_req0", int'(req0_ready), 1);
    check("post_reset_req1", int'(req1_ready), 0);
    if (req0_ready) push_exp(1'b0, 3'd5, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
